// File: rtl/seg_pipe_reg.sv
// seg_pipe_reg: pipeline segment register placed between two pipeline stages.
// Carries a DATA_W payload plus a CTRL_W control bundle over a valid/ready
// handshake. It adds flush (bubble insert), a debug clock-enable freeze and
// halt propagation. Once a HALT beat is accepted, further acceptance stops.
//
// Build option:
//   SEG_PIPE_SKID_EN  defined   -> two entries (head + skid). o_ready comes
//                                  only from registers. o_count is 0..2.
//                     undefined -> single head entry. o_ready also depends
//                                  combinationally on i_ready. o_count is
//                                  0..1.
//
// The head entry always drives the outputs. The control bundle and the halt
// flag are masked to zero whenever the slot is not valid, so a bubble can never
// commit architectural state downstream.
`timescale 1ns/1ps

module seg_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clk_en,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_halt,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_halt,
  output logic              o_halted,
  output logic [1:0]        o_count
);

  // Returns the control bundle only for an occupied slot; otherwise all zero.
  function automatic logic [CTRL_W-1:0] slot_ctrl(input logic              vld,
                                                   input logic [CTRL_W-1:0] ctrl);
    logic [CTRL_W-1:0] res;
    if (vld) begin
      res = ctrl;
    end else begin
      res = {CTRL_W{1'b0}};
    end
    return res;
  endfunction

  // Head entry: this is the beat currently presented downstream.
  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic              head_halt;
  logic              head_valid_nxt;
  logic [DATA_W-1:0] head_data_nxt;
  logic [CTRL_W-1:0] head_ctrl_nxt;
  logic              head_halt_nxt;

  // Bookkeeping state.
  logic halt_seen;      // a HALT beat was accepted; blocks further accepts
  logic halt_seen_nxt;
  logic halted;         // a HALT beat has left the segment (sticky)
  logic halted_nxt;
  logic rst_done;       // low until the first clock edge after reset release
  logic rst_done_nxt;

  // Handshake qualifiers.
  logic accept;
  logic emit;

  // The output slot is hidden while the debug unit freezes the segment.
  assign o_valid  = head_valid & i_clk_en;
  assign o_data   = head_data;
  assign o_ctrl   = slot_ctrl(o_valid, head_ctrl);
  assign o_halt   = o_valid & head_halt;
  assign o_halted = halted;

  assign accept = i_valid & o_ready;
  assign emit   = o_valid & i_ready;

`ifdef SEG_PIPE_SKID_EN

  // Skid entry: holds the overflow beat while the head is stalled.
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_halt;
  logic              skid_valid_nxt;
  logic [DATA_W-1:0] skid_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl_nxt;
  logic              skid_halt_nxt;

  // Ready is built only from registered state, so i_ready does not feed it.
  assign o_ready = ~skid_valid & ~halt_seen & rst_done & i_clk_en;

  // The count is 2 whenever the skid entry is occupied, because the skid is
  // only ever filled behind a full head.
  assign o_count = skid_valid ? 2'd2 : (head_valid ? 2'd1 : 2'd0);

  // Next-state logic for head, skid and flags. Flush overrides every
  // transfer, and a frozen segment holds all of its state.
  always_comb begin
    head_valid_nxt = head_valid;
    head_data_nxt  = head_data;
    head_ctrl_nxt  = head_ctrl;
    head_halt_nxt  = head_halt;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    skid_ctrl_nxt  = skid_ctrl;
    skid_halt_nxt  = skid_halt;
    halt_seen_nxt  = halt_seen;
    halted_nxt     = halted;
    rst_done_nxt   = rst_done;

    if (i_clk_en) begin
      rst_done_nxt = 1'b1;
      if (i_flush) begin
        head_valid_nxt = 1'b0;
        skid_valid_nxt = 1'b0;
        halt_seen_nxt  = 1'b0;
      end else begin
        if (accept && i_halt) begin
          halt_seen_nxt = 1'b1;
        end else begin
          halt_seen_nxt = halt_seen;
        end

        if (emit && o_halt) begin
          halted_nxt = 1'b1;
        end else begin
          halted_nxt = halted;
        end

        case ({skid_valid, head_valid})
          // Empty: an accepted beat lands directly in the head.
          2'b00: begin
            if (accept) begin
              head_valid_nxt = 1'b1;
              head_data_nxt  = i_data;
              head_ctrl_nxt  = i_ctrl;
              head_halt_nxt  = i_halt;
            end else begin
              head_valid_nxt = 1'b0;
            end
          end
          // One beat held.
          2'b01: begin
            if (accept && emit) begin
              head_data_nxt  = i_data;
              head_ctrl_nxt  = i_ctrl;
              head_halt_nxt  = i_halt;
            end else if (accept) begin
              skid_valid_nxt = 1'b1;
              skid_data_nxt  = i_data;
              skid_ctrl_nxt  = i_ctrl;
              skid_halt_nxt  = i_halt;
            end else if (emit) begin
              head_valid_nxt = 1'b0;
            end else begin
              head_valid_nxt = 1'b1;
            end
          end
          // Full: o_ready is low, so the only possible move is skid to head.
          2'b11: begin
            if (emit) begin
              head_data_nxt  = skid_data;
              head_ctrl_nxt  = skid_ctrl;
              head_halt_nxt  = skid_halt;
              skid_valid_nxt = 1'b0;
            end else begin
              skid_valid_nxt = 1'b1;
            end
          end
          // A skid beat with an empty head is not reachable. If it ever
          // occurs, promote the skid beat so that FIFO order is kept.
          default: begin
            head_valid_nxt = 1'b1;
            head_data_nxt  = skid_data;
            head_ctrl_nxt  = skid_ctrl;
            head_halt_nxt  = skid_halt;
            skid_valid_nxt = 1'b0;
          end
        endcase
      end
    end else begin
      rst_done_nxt = rst_done;
    end
  end

  // Skid entry storage, cleared asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skid_valid <= 1'b0;
      skid_data  <= {DATA_W{1'b0}};
      skid_ctrl  <= {CTRL_W{1'b0}};
      skid_halt  <= 1'b0;
    end else begin
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_ctrl  <= skid_ctrl_nxt;
      skid_halt  <= skid_halt_nxt;
    end
  end

`else

  // Single entry: the slot can refill in the same cycle that downstream takes
  // it, which makes ready depend combinationally on i_ready.
  assign o_ready = (~o_valid | i_ready) & ~halt_seen & rst_done & i_clk_en;

  assign o_count = {1'b0, head_valid};

  // Next-state logic for the single head entry and flags. Flush overrides
  // every transfer, and a frozen segment holds all of its state.
  always_comb begin
    head_valid_nxt = head_valid;
    head_data_nxt  = head_data;
    head_ctrl_nxt  = head_ctrl;
    head_halt_nxt  = head_halt;
    halt_seen_nxt  = halt_seen;
    halted_nxt     = halted;
    rst_done_nxt   = rst_done;

    if (i_clk_en) begin
      rst_done_nxt = 1'b1;
      if (i_flush) begin
        head_valid_nxt = 1'b0;
        halt_seen_nxt  = 1'b0;
      end else begin
        if (accept && i_halt) begin
          halt_seen_nxt = 1'b1;
        end else begin
          halt_seen_nxt = halt_seen;
        end

        if (emit && o_halt) begin
          halted_nxt = 1'b1;
        end else begin
          halted_nxt = halted;
        end

        if (accept) begin
          head_valid_nxt = 1'b1;
          head_data_nxt  = i_data;
          head_ctrl_nxt  = i_ctrl;
          head_halt_nxt  = i_halt;
        end else if (emit) begin
          head_valid_nxt = 1'b0;
        end else begin
          head_valid_nxt = head_valid;
        end
      end
    end else begin
      rst_done_nxt = rst_done;
    end
  end

`endif

  // Head entry storage, cleared asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_valid <= 1'b0;
      head_data  <= {DATA_W{1'b0}};
      head_ctrl  <= {CTRL_W{1'b0}};
      head_halt  <= 1'b0;
    end else begin
      head_valid <= head_valid_nxt;
      head_data  <= head_data_nxt;
      head_ctrl  <= head_ctrl_nxt;
      head_halt  <= head_halt_nxt;
    end
  end

  // Halt tracking and the post-reset ready qualifier.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      halt_seen <= 1'b0;
      halted    <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      halt_seen <= halt_seen_nxt;
      halted    <= halted_nxt;
      rst_done  <= rst_done_nxt;
    end
  end

endmodule

// File: tb/tb_seg_pipe_reg.sv
// Directed testbench for seg_pipe_reg. Expected values are hand-computed, and
// the expectations adapt to the SEG_PIPE_SKID_EN build option.
`timescale 1ns/1ps

module tb_seg_pipe_reg;

  localparam int DW = 32;
  localparam int CW = 8;
`ifdef SEG_PIPE_SKID_EN
  localparam logic [1:0] EXP_FULL = 2'd2;
`else
  localparam logic [1:0] EXP_FULL = 2'd1;
`endif

  logic          i_clk;
  logic          i_reset_n;
  logic          i_clk_en;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_ctrl;
  logic          i_halt;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic          o_halt;
  logic          o_halted;
  logic [1:0]    o_count;

  int total;
  int bad;

  seg_pipe_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clk_en  (i_clk_en),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_ctrl    (i_ctrl),
    .i_halt    (i_halt),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_ctrl    (o_ctrl),
    .o_halt    (o_halt),
    .o_halted  (o_halted),
    .o_count   (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Control bundle attached to each streamed payload.
  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[7:0] ^ 8'hA5;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_valid = 1'b1; i_data = 32'h1234_5678; i_ctrl = 8'hFF; i_ready = 1'b1;
    tick(); tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
    total++; if (o_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", o_data); end
    total++; if (o_ctrl !== 8'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=0", o_ctrl); end
    total++; if (o_halt !== 1'b0 || o_halted !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b%b want=00", o_halt, o_halted); end
    total++; if (o_count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", o_count); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", o_ready); end
    i_reset_n = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    tick();
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b want=1", o_ready); end
    i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_ctrl = 8'h81;
    tick();
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", o_valid); end
    total++; if (o_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL first_data got=%h want=deadbeef", o_data); end
    total++; if (o_ctrl !== 8'h81) begin bad++; $display("FAIL first_ctrl got=%h want=81", o_ctrl); end
    total++; if (o_count !== 2'd1) begin bad++; $display("FAIL first_count got=%0d want=1", o_count); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    total++; if (o_valid !== 1'b0 || o_ctrl !== 8'h0) begin bad++; $display("FAIL drain_empty got=%b/%h want=0/00", o_valid, o_ctrl); end
    total++; if (o_count !== 2'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", o_count); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] beats [3];
    int idx;
    int got;
    logic acc;
    beats[0] = 32'd1; beats[1] = 32'd2; beats[2] = 32'd3;
    idx = 0; got = 0;
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1; i_data = beats[idx]; i_ctrl = ctrl_of(beats[idx]);
      #1;
      acc = o_ready;
      tick();
      if (acc) idx++;
    end
    total++; if (o_count !== EXP_FULL) begin bad++; $display("FAIL bp_count got=%0d want=%0d", o_count, EXP_FULL); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", o_ready); end
    total++; if (o_data !== 32'd1) begin bad++; $display("FAIL bp_head got=%h want=1", o_data); end
    i_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (idx == 3 && o_valid === 1'b0) break;
      i_valid = (idx < 3);
      i_data = (idx < 3) ? beats[idx] : 32'h0;
      i_ctrl = ctrl_of(i_data);
      #1;
      acc = i_valid & o_ready;
      if (o_valid === 1'b1) begin
        total++;
        if (got >= 3) begin
          bad++; $display("FAIL bp_extra got=%h want=none", o_data);
        end else if (o_data !== beats[got] || o_ctrl !== ctrl_of(beats[got])) begin
          bad++; $display("FAIL bp_order got=%h/%h want=%h/%h", o_data, o_ctrl, beats[got], ctrl_of(beats[got]));
        end else begin
        end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    i_valid = 1'b0; i_ready = 1'b0;
    total++; if (got !== 3) begin bad++; $display("FAIL bp_total got=%0d want=3", got); end
    total++; if (o_count !== 2'd0) begin bad++; $display("FAIL bp_end_count got=%0d want=0", o_count); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      i_valid = 1'b1; i_data = 32'h100 * (c + 1); i_ctrl = 8'h5A;
      tick();
    end
    total++; if (o_count !== EXP_FULL) begin bad++; $display("FAIL fl_fill got=%0d want=%0d", o_count, EXP_FULL); end
    i_valid = 1'b1; i_data = 32'h0BAD; i_ctrl = 8'hEE; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    total++; if (o_valid !== 1'b0 || o_ctrl !== 8'h0) begin bad++; $display("FAIL fl_out got=%b/%h want=0/00", o_valid, o_ctrl); end
    total++; if (o_count !== 2'd0) begin bad++; $display("FAIL fl_count got=%0d want=0", o_count); end
    // Flush while empty: the beat offered in the same cycle must be dropped.
    i_valid = 1'b1; i_data = 32'h0BAD2; i_ctrl = 8'hEF; i_flush = 1'b1;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b want=1", o_ready); end
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fl_leak got=%b data=%h want=0", o_valid, o_data); end
      tick();
    end
    i_ready = 1'b0;
  endtask

  task automatic test_halt();
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'h77; i_ctrl = 8'h11; i_halt = 1'b1;
    tick();
    i_data = 32'h88; i_halt = 1'b0;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL h_ready got=%b want=0", o_ready); end
    total++; if (o_halt !== 1'b1 || o_data !== 32'h77) begin bad++; $display("FAIL h_head got=%b/%h want=1/77", o_halt, o_data); end
    tick();
    i_ready = 1'b1;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL h_block got=%b want=0", o_ready); end
    total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL h_early got=%b want=0", o_halted); end
    tick();
    total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL h_halted got=%b want=1", o_halted); end
    total++; if (o_valid !== 1'b0 || o_halt !== 1'b0) begin bad++; $display("FAIL h_gone got=%b/%b want=0/0", o_valid, o_halt); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL h_stuck got=%b want=0", o_ready); end
    i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL h_unflush got=%b want=1", o_ready); end
    total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL h_sticky got=%b want=1", o_halted); end
  endtask

  task automatic test_freeze();
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'h55; i_ctrl = 8'h3C;
    tick();
    i_valid = 1'b0; i_clk_en = 1'b0; i_ready = 1'b1; i_flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (o_valid !== 1'b0 || o_ready !== 1'b0) begin bad++; $display("FAIL fz_hs got=%b/%b want=0/0", o_valid, o_ready); end
      total++; if (o_count !== 2'd1 || o_ctrl !== 8'h0 || o_data !== 32'h55) begin bad++; $display("FAIL fz_hold got=%0d/%h/%h want=1/00/55", o_count, o_ctrl, o_data); end
      tick();
    end
    i_clk_en = 1'b1; i_flush = 1'b0;
    #1;
    total++; if (o_valid !== 1'b1 || o_data !== 32'h55 || o_ctrl !== 8'h3C) begin bad++; $display("FAIL fz_resume got=%b/%h/%h want=1/55/3c", o_valid, o_data, o_ctrl); end
    tick();
    i_ready = 1'b0;
    total++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin bad++; $display("FAIL fz_once got=%b/%0d want=0/0", o_valid, o_count); end
  endtask

  task automatic test_back_to_back();
    int idx;
    int got;
    logic acc;
    // Phase 1: i_ready toggles every cycle under continuous i_valid.
    idx = 0; got = 0;
    for (int c = 0; c < 30; c++) begin
      if (idx == 6 && got == 6) break;
      i_ready = (c % 2 == 0);
      i_valid = (idx < 6);
      i_data = 32'h1000 + idx; i_ctrl = ctrl_of(i_data);
      #1;
`ifndef SEG_PIPE_SKID_EN
      total++; if (o_ready !== (~o_valid | i_ready)) begin bad++; $display("FAIL tg_ready got=%b want=%b", o_ready, ~o_valid | i_ready); end
`endif
      acc = i_valid & o_ready;
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        total++; if (o_data !== 32'h1000 + got) begin bad++; $display("FAIL tg_order got=%h want=%h", o_data, 32'h1000 + got); end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    i_valid = 1'b0; i_ready = 1'b0;
    total++; if (got !== 6) begin bad++; $display("FAIL tg_total got=%0d want=6", got); end
    // Phase 2: full throughput, six beats in seven cycles.
    idx = 0; got = 0;
    i_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      i_valid = (idx < 6);
      i_data = 32'h2000 + idx; i_ctrl = ctrl_of(i_data);
      #1;
      if (i_valid) begin
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bb_ready cyc=%0d got=%b want=1", c, o_ready); end
      end
      acc = i_valid & o_ready;
      if (o_valid === 1'b1) begin
        total++; if (o_data !== 32'h2000 + got) begin bad++; $display("FAIL bb_order got=%h want=%h", o_data, 32'h2000 + got); end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    i_valid = 1'b0; i_ready = 1'b0;
    total++; if (got !== 6) begin bad++; $display("FAIL bb_total got=%0d want=6", got); end
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'hCAFE; i_ctrl = 8'h42;
    tick();
    i_valid = 1'b0;
    #2;
    i_reset_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin bad++; $display("FAIL ar_clear got=%b/%0d want=0/0", o_valid, o_count); end
    total++; if (o_halted !== 1'b0 || o_data !== 32'h0) begin bad++; $display("FAIL ar_regs got=%b/%h want=0/0", o_halted, o_data); end
    tick();
    i_reset_n = 1'b1;
    tick();
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin bad++; $display("FAIL ar_release got=%b/%b want=1/0", o_ready, o_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    i_reset_n = 1'b0; i_clk_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
    i_data = 32'h0; i_ctrl = 8'h0; i_halt = 1'b0; i_ready = 1'b0;
    test_reset();
    test_backpressure();
    test_flush();
    test_halt();
    test_freeze();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_pipe_reg.md
# seg_pipe_reg

Parametrised pipeline segment register used between any two pipeline stages (IF/ID through MEM/WB). It carries a DATA_W-bit payload and a CTRL_W-bit control bundle with a valid/ready handshake, so one segment type serves every stage boundary. It adds the following:
- flush (bubble insert);
- debug clock-enable freeze;
- halt propagation with halt-gated acceptance;
- an optional 2-entry skid buffer that gives full throughput under back-pressure.

## Interface
Parameters:
- DATA_W, 32, payload width (ALU result, read data, PC, …).
- CTRL_W, 8, control bundle width (reg_write, mem_to_reg, rd, …); zeroed whenever the slot is invalid.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_clk_en  in  1  debug-unit enable; 0 freezes all state.
- i_flush  in  1  synchronous flush; drops all held beats.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  segment can accept a beat.
- i_data  in  DATA_W  upstream payload.
- i_ctrl  in  CTRL_W  upstream control bundle.
- i_halt  in  1  upstream beat is a HALT.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_W  payload to next stage.
- o_ctrl  out  CTRL_W  control bundle to next stage; all-zero when o_valid=0.
- o_halt  out  1  head beat is a HALT; 0 when o_valid=0.
- o_halted  out  1  sticky; a HALT beat has left the segment.
- o_count  out  2  held beats (0..2; max 1 without skid).

## Operation
- Transfers:
  - Accept = i_valid & o_ready.
  - Emit = o_valid & i_ready.
  - Both may occur in the same cycle.
- Order is strict FIFO. The head (main) entry drives the outputs; the skid entry holds the overflow beat.
- halt_seen flag:
  - Set when an accepted beat carries i_halt=1.
  - While set, o_ready=0 and no further beats are accepted.
  - Cleared by flush or reset.
- o_halted:
  - Set on an Emit with o_halt=1.
  - Cleared only by reset.
- Flush (i_flush=1 with i_clk_en=1):
  - Next cycle: o_valid=0, o_count=0, halt_seen=0.
  - Any Accept in the same cycle is discarded.
  - Flush has priority over all transfers. o_halted is unaffected.
- Freeze (i_clk_en=0):
  - All registers hold, o_ready=0 and o_valid=0, so no transfers occur.
  - o_data is unchanged and o_ctrl is zero.
  - i_flush is ignored.
- Invalid-slot rule: o_ctrl and o_halt are forced to 0 whenever o_valid=0. A bubble can never write the register file or memory.
- Reset values, while i_reset_n=0 and immediately after release:
  - o_valid=0, o_data=0, o_ctrl=0, o_halt=0, o_halted=0, o_count=0.
  - o_ready=0 while reset is asserted, and 1 from the first cycle after release.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on the outputs after edge N.
- Throughput is 1 beat/cycle with continuous i_ready=1.
- Skid mode, o_ready is registered: o_ready = ~skid_full & ~halt_seen & i_clk_en.
- Skid mode, entry behaviour:
  - Accept with head full and no Emit: the beat goes to skid; o_count becomes 2 and o_ready becomes 0 next cycle.
  - Emit with skid full: skid moves to head. The skid entry can then reload from an Accept in the same cycle only if o_ready was 1.
  - Simultaneous Accept and Emit with o_count=1: the head is replaced and o_count stays 1.
- Non-skid mode, o_ready is combinational: o_ready = (~o_valid | i_ready) & ~halt_seen & i_clk_en. This creates an i_ready→o_ready path.
- Mid-operation reset clears all entries asynchronously; in-flight beats are lost.

## Configuration
- SEG_PIPE_SKID_EN defined:
  - 2-entry storage with registered o_ready.
  - No combinational ready path.
  - o_count ranges 0..2.
- SEG_PIPE_SKID_EN undefined:
  - Single entry, with o_ready combinational from i_ready.
  - o_count ranges 0..1.
  - Skid storage is not instantiated.

## Test plan
- Reset:
  - Hold i_reset_n=0 with i_valid=1 → all outputs 0 and o_ready=0.
  - Release → o_ready=1 next cycle.
  - Drive i_valid=1, i_data=0xDEADBEEF, i_ctrl=0x81 → o_valid=1, o_data=0xDEADBEEF, o_ctrl=0x81 one cycle later.
- Back-pressure (skid):
  - Stream beats 1,2,3 with i_ready=0 → o_count=2, o_ready=0, o_data=1.
  - Raise i_ready → emits 1,2,3 in order with no loss or duplication.
- Flush:
  - With o_count=2, assert i_flush together with i_valid=1 → next cycle o_valid=0, o_ctrl=0, o_count=0.
  - The flushed beat never appears on the outputs.
- Halt:
  - Accept a beat with i_halt=1 → o_ready=0 from then on.
  - Emit it → o_halted=1.
  - Flush → o_ready returns to 1, o_halted remains 1.
- Freeze:
  - With o_count=1, drop i_clk_en for 3 cycles with i_ready=1 → o_valid=0, o_count stays 1.
  - Re-enable → the held beat emits once.
- Non-skid build: i_ready toggling every cycle with continuous i_valid → o_ready mirrors (~o_valid | i_ready) in the same cycle and no beat is lost.
